mpsk_dds_modulator: RTL
=======================

Name: mpsk_dds_modulator

Overview:
- Parametrised M-PSK modulator: phase-accumulator DDS with a programmable tuning word, a symbol-rate handshake input, and BPSK/QPSK/8-PSK constellation selection.
- Emits an unmodulated reference carrier and the phase-modulated carrier from one shared accumulator.
- Symbol phase is applied as an absolute offset per symbol. It is never accumulated into the phase register.
- Sits between the symbol source (framer/FIFO) and the DAC interface in the 8-PSK transmit chain.

Parameters:
- ACC_W, 32, phase accumulator width.
- LUT_AW, 8, phase bits used to address one full sine cycle (quarter-wave ROM holds 2^(LUT_AW-2) entries).
- OUT_W, 8, output sample width, offset-binary unsigned (midscale 2^(OUT_W-1)).
- SPS_W, 16, width of the cycles-per-symbol field.
- FTW_DEFAULT, 42949673, tuning word loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ftw_i  in  ACC_W  frequency tuning word
- ftw_load  in  1  load ftw_i into the tuning register
- mode  in  2  00 BPSK, 01 QPSK, 10 8-PSK, 11 reserved (treated as 8-PSK)
- sym_len  in  SPS_W  clock cycles per symbol
- sym_data  in  3  symbol index; only the low log2(M) bits are used
- sym_valid  in  1  symbol available
- sym_ready  out  1  symbol accepted this cycle when sym_valid is also high
- carrier_out  out  OUT_W  unmodulated sine
- mod_out  out  OUT_W  modulated sine
- out_valid  out  1  output pipeline primed
- sym_strobe  out  1  one-cycle pulse when a new symbol phase is applied
- underrun  out  1  one-cycle pulse when a symbol boundary has no data

Behaviour:
- Reset state:
  - acc = 0, ftw = FTW_DEFAULT, sym_phase = 0, state IDLE.
  - carrier_out = mod_out = 2^(OUT_W-1).
  - out_valid, sym_ready, sym_strobe and underrun = 0.
- Tuning:
  - acc <= acc + ftw every cycle, wrapping modulo 2^ACC_W.
  - ftw_load writes ftw on that edge; the new word is first added on the following cycle.
- Symbol phase mapping:
  - BPSK: sym_data[0] << (ACC_W-1).
  - QPSK: sym_data[1:0] << (ACC_W-2).
  - 8-PSK: sym_data[2:0] << (ACC_W-3).
  - mode is sampled together with sym_data at acceptance.
- Modulated phase: mod_phase = acc + sym_phase, modulo 2^ACC_W. Carrier phase is acc.
- FSM IDLE:
  - sym_ready = 1 and sym_phase = 0.
  - On sym_valid, accept the symbol, load sym_phase, pulse sym_strobe, set cnt = max(sym_len,1) - 1, and go to RUN.
- FSM RUN:
  - cnt decrements each cycle.
  - sym_ready = (cnt == 0).
  - At cnt == 0 with sym_valid: accept the next symbol back-to-back, with no gap cycle. Reload cnt from the current sym_len and pulse sym_strobe.
  - At cnt == 0 without sym_valid: pulse underrun, set sym_phase = 0, and go to IDLE.
- Symbol timing:
  - sym_len is sampled only at acceptance, so mid-symbol changes have no effect.
  - sym_len = 0 behaves as 1, giving one symbol per cycle.
- Output pipeline, 2 cycles from phase to output:
  - Stage 1 registers the top LUT_AW bits of each phase as quadrant (2 MSBs) and index.
  - Stage 2 registers the ROM result and applies the quadrant fold.
  - A phase change on cycle n appears on the outputs at cycle n+2.
  - sym_strobe and underrun are aligned to the phase change, not to the output.
- out_valid rises on the 2nd edge after reset release and stays high.
- Quarter-wave fold, with q = rom[i] in 0..2^(OUT_W-1)-1:
  - Quadrant 0: mid + rom[i].
  - Quadrant 1: mid + rom[N-1-i].
  - Quadrant 2: mid - 1 - rom[i].
  - Quadrant 3: mid - 1 - rom[N-1-i].
  - This gives exact antisymmetry: sample(phase + half cycle) = 2^OUT_W - 1 - sample(phase).
- ROM contents: rom[i] = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5)/N)), with N = 2^(LUT_AW-2).
- Reset mid-symbol: all state clears immediately, with no pending-symbol retention. The symbol in flight is dropped.

Decomposition:
- Package mpsk_pkg holds:
  - Mode encodings MODE_BPSK/QPSK/8PSK.
  - Function phase_of_symbol(mode, sym, ACC_W).
  - Function midscale(OUT_W).
- Sub-module sine_quarter_rom (parameters LUT_AW, OUT_W): registered quarter-wave read plus fold, instantiated twice (carrier and mod paths).

Test Plan:
- Reset release with ftw = 2^24 (loaded via ftw_load), defaults otherwise -> carrier_out period exactly 256 cycles; out_valid high 2 cycles after release; sample 64 cycles after the first midscale value is 255.
- BPSK, sym_len = 32, symbols 1,0,1 back-to-back -> during a symbol-1 window, mod_out = 255 - carrier_out every cycle; sym_ready high only on cycles 31, 63 and 95 of the run.
- 8-PSK, ftw = 2^24, sym_data = 2 -> mod_out equals carrier_out delayed by -64 samples (90 degrees); sym_data = 4 -> mod_out = 255 - carrier_out.
- sym_valid dropped after one QPSK symbol of sym_len = 10 -> underrun pulses once at the boundary; state returns to IDLE; mod_out equals carrier_out from 2 cycles later.
- sym_len = 0 with sym_valid held high -> one symbol accepted every cycle; sym_strobe continuously high; no underrun.
- rst asserted mid-symbol at cnt = 5 -> the next sampled outputs are midscale; sym_ready = 0; after release the block accepts a fresh symbol in IDLE.

Source files
------------

// File: rtl/mpsk_pkg.sv
// Shared definitions for the M-PSK DDS modulator: mode encodings, FSM states,
// symbol-to-phase mapping and elaboration-time quarter-sine table generation.
package mpsk_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK = 2'b00,
    MODE_QPSK = 2'b01,
    MODE_8PSK = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // pi in Q28, used only while building the sine table at elaboration
  localparam longint PI_Q28 = 64'sd843314857;

  function automatic logic [63:0] phase_of_symbol(input logic [1:0] mode,
                                                  input logic [2:0] sym,
                                                  input int unsigned acc_w);
    logic [63:0] p;
    case (mode_e'(mode))
      MODE_BPSK: p = 64'(sym[0]) << (acc_w - 1);
      MODE_QPSK: p = 64'(sym[1:0]) << (acc_w - 2);
      default:   p = 64'(sym) << (acc_w - 3);
    endcase
    return p;
  endfunction

  function automatic logic [31:0] midscale(input int unsigned out_w);
    return 32'd1 << (out_w - 1);
  endfunction

  // round(amp * sin(pi/2 * (i+0.5)/N)) via fixed-point Taylor series
  function automatic logic [31:0] quarter_sine(input int unsigned i,
                                               input int unsigned lut_aw,
                                               input int unsigned out_w);
    longint n, x, x2, term, s, amp;
    n    = longint'(1) << (lut_aw - 2);
    x    = (PI_Q28 * longint'(2 * i + 1)) / (4 * n);
    x2   = (x * x) >>> 28;
    term = x;
    s    = x;
    for (int unsigned k = 1; k < 8; k++) begin
      term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    amp = (longint'(1) << (out_w - 1)) - 1;
    return 32'((amp * s + (longint'(1) << 27)) >>> 28);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Two-stage sine lookup: registers quadrant/index, then reads the quarter-wave
// table and folds it into a full offset-binary cycle.
module sine_quarter_rom
  import mpsk_pkg::*;
#(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] phase_msb,
  output logic [OUT_W-1:0]  sample
);

  localparam int unsigned N  = 2 ** (LUT_AW - 2);
  localparam int unsigned RW = OUT_W - 1;
  localparam logic [OUT_W-1:0] MID    = OUT_W'(midscale(OUT_W));
  localparam logic [OUT_W-1:0] MID_M1 = OUT_W'(midscale(OUT_W) - 32'd1);

  logic [RW-1:0] rom [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam logic [RW-1:0] V = RW'(quarter_sine(g, LUT_AW, OUT_W));
    assign rom[g] = V;
  end

  logic [1:0]        quad;
  logic [LUT_AW-3:0] idx;
  logic [LUT_AW-3:0] addr;
  logic [OUT_W-1:0]  mag;
  logic [OUT_W-1:0]  folded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad <= '0;
      idx  <= '0;
    end else begin
      quad <= phase_msb[LUT_AW-1 -: 2];
      idx  <= phase_msb[LUT_AW-3:0];
    end
  end

  // odd quadrants walk the table backwards (N-1-i == ~i); lower half mirrors to mid-1-q
  always_comb begin
    addr   = quad[0] ? ~idx : idx;
    mag    = {1'b0, rom[addr]};
    folded = quad[1] ? (MID_M1 - mag) : (MID + mag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample <= MID;
    else     sample <= folded;
  end

endmodule

// File: rtl/mpsk_dds_modulator.sv
// M-PSK modulator: one phase accumulator drives a reference carrier and a
// carrier offset by the current symbol phase, paced by a symbol handshake.
module mpsk_dds_modulator
  import mpsk_pkg::*;
#(
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      LUT_AW      = 8,
  parameter int unsigned      OUT_W       = 8,
  parameter int unsigned      SPS_W       = 16,
  parameter logic [ACC_W-1:0] FTW_DEFAULT = ACC_W'(42949673)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] ftw_i,
  input  logic             ftw_load,
  input  logic [1:0]       mode,
  input  logic [SPS_W-1:0] sym_len,
  input  logic [2:0]       sym_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [OUT_W-1:0] carrier_out,
  output logic [OUT_W-1:0] mod_out,
  output logic             out_valid,
  output logic             sym_strobe,
  output logic             underrun
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw;
  logic [2:0]        sym_off;
  state_e            state;
  logic [SPS_W-1:0]  cnt;
  logic [SPS_W-1:0]  len_m1;
  logic [LUT_AW-1:0] acc_msb;
  logic [LUT_AW-1:0] mod_msb;
  logic              primed;

  // Symbol phase only ever occupies the top 3 phase bits, so it is held as an
  // eighth-cycle count and added to the LUT address bits alone (no low carry).
  always_comb begin
    len_m1  = (sym_len == '0) ? '0 : sym_len - SPS_W'(1);
    acc_msb = acc[ACC_W-1 -: LUT_AW];
    mod_msb = acc_msb + (LUT_AW'(sym_off) << (LUT_AW - 3));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ftw <= FTW_DEFAULT;
    end else begin
      acc <= acc + ftw;
      if (ftw_load) ftw <= ftw_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sym_off    <= '0;
      sym_ready  <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      if (sym_ready && sym_valid) begin
        state      <= ST_RUN;
        cnt        <= len_m1;
        sym_off    <= 3'(phase_of_symbol(mode, sym_data, 3));
        sym_strobe <= 1'b1;
        sym_ready  <= (len_m1 == '0);
      end else begin
        case (state)
          ST_IDLE: begin
            sym_off   <= '0;
            sym_ready <= 1'b1;
          end
          ST_RUN: begin
            if (cnt == '0) begin
              underrun  <= 1'b1;
              sym_off   <= '0;
              state     <= ST_IDLE;
              sym_ready <= 1'b1;
            end else begin
              cnt       <= cnt - SPS_W'(1);
              sym_ready <= (cnt == SPS_W'(1));
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      primed    <= 1'b1;
      out_valid <= primed;
    end
  end

  sine_quarter_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_carrier_rom (
    .clk       (clk),
    .rst       (rst),
    .phase_msb (acc_msb),
    .sample    (carrier_out)
  );

  sine_quarter_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_mod_rom (
    .clk       (clk),
    .rst       (rst),
    .phase_msb (mod_msb),
    .sample    (mod_out)
  );

endmodule
